mux4_rr_scheduler: RTL and testbench



---
 rtl/mux4_rr_scheduler_pkg.sv | 20 ++
 rtl/multiplexer4to1.sv | 14 +
 rtl/mux4_rr_scheduler.sv | 126 ++++++++++++
 tb/tb_mux4_rr_scheduler.sv | 138 +++++++++++++
 4 files changed

// File: rtl/mux4_rr_scheduler_pkg.sv
// Shared definitions for the 4-requester round-robin mux scheduler.
// Holds the FSM state encoding, the default burst length and a small
// one-hot helper used by the scheduler when decoding a select index.
package mux4_rr_scheduler_pkg;

  // Scheduler FSM: IDLE = no grant outstanding, GRANT = a burst is active.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Default maximum burst length (cycles a requester may hold the grant).
  localparam int HOLD_CYCLES_DEFAULT = 4;

  // Decode a 2-bit requester index into a 4-bit one-hot grant vector.
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/multiplexer4to1.sv
// Existing single-bit 4:1 multiplexer on the shared data path.
// Ports:
//   out : selected data bit, i[s]
//   i   : four candidate data bits
//   s   : 2-bit select index
module multiplexer4to1 (
  output logic       out,
  input  logic [3:0] i,
  input  logic [1:0] s
);

  assign out = i[s];

endmodule

// File: rtl/mux4_rr_scheduler.sv
// Round-robin scheduler sharing one 4:1 single-bit mux among four
// requesters. Each grant is held for at most HOLD_CYCLES cycles, then the
// next active requester (searching upward from the last one served) takes
// over at the same edge, so back-to-back bursts have no idle bubble.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst   : synchronous active-high reset
//   req   : per-requester request lines
//   i     : per-requester data bits
//   gnt   : registered one-hot grant, zero when idle
//   s     : registered mux select (index of granted requester)
//   out   : valid & i[s], combinational from i
//   valid : high while a grant is active
module mux4_rr_scheduler
  import mux4_rr_scheduler_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] i,
  output logic [3:0] gnt,
  output logic [1:0] s,
  output logic       out,
  output logic       valid
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [3:0]       gnt_reg, gnt_next;
  logic [1:0]       s_reg, s_next;
  logic [1:0]       last_reg, last_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       pick;
  logic             mux_out;

  // First requester found searching last+1, last+2, last+3, last (mod 4).
  // Walking the offsets from 4 down to 1 lets the nearest hit win, so the
  // last-served requester is only chosen when it is the sole requester.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign pick = rr_pick(req, last_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      gnt_reg   <= 4'b0000;
      s_reg     <= 2'd0;
      last_reg  <= 2'd3;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      s_reg     <= s_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    s_next     = s_reg;
    last_next  = last_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (|req) begin
          state_next = ST_GRANT;
          gnt_next   = onehot4(pick);
          s_next     = pick;
          last_next  = pick;
          cnt_next   = '0;
        end
      end
      ST_GRANT: begin
        if (req[s_reg] && (cnt_reg < CNT_MAX)) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end else if (|req) begin
          // Burst over with other work pending: hand over at this edge.
          gnt_next  = onehot4(pick);
          s_next    = pick;
          last_next = pick;
          cnt_next  = '0;
        end else begin
          // Nobody waiting: drop the grant, keep s steady while idle.
          state_next = ST_IDLE;
          gnt_next   = 4'b0000;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        gnt_next   = 4'b0000;
        cnt_next   = '0;
      end
    endcase
  end

  multiplexer4to1 u_mux (
    .out (mux_out),
    .i   (i),
    .s   (s_reg)
  );

  assign gnt   = gnt_reg;
  assign s     = s_reg;
  assign valid = |gnt_reg;
  assign out   = valid & mux_out;

  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_reg));
  a_gnt_matches_s : assert property (@(posedge clk) disable iff (rst)
                                     (|gnt_reg) |-> (gnt_reg == onehot4(s_reg)));
  a_cnt_bound : assert property (@(posedge clk) disable iff (rst) cnt_reg <= CNT_MAX);

endmodule

// File: tb/tb_mux4_rr_scheduler.sv
module tb_mux4_rr_scheduler;

  typedef struct {
    bit         sel;    // 0 = HOLD_CYCLES=4 instance, 1 = HOLD_CYCLES=1 instance
    bit         rst;
    logic [3:0] req;
    logic [3:0] i;
    logic [3:0] gnt;
    logic [1:0] s;
    logic       valid;
    logic       out;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst0, rst1;
  logic [3:0] req0, req1, i0, i1;
  logic [3:0] gnt0, gnt1;
  logic [1:0] s0, s1;
  logic       out0, out1, valid0, valid1;

  int n_cmp = 0;
  int n_bad = 0;

  vec_t vecs[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  mux4_rr_scheduler #(.HOLD_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst0), .req(req0), .i(i0),
    .gnt(gnt0), .s(s0), .out(out0), .valid(valid0)
  );

  mux4_rr_scheduler #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst1), .req(req1), .i(i1),
    .gnt(gnt1), .s(s1), .out(out1), .valid(valid1)
  );

  function automatic void add(bit sel, bit r, logic [3:0] rq, logic [3:0] d,
                              logic [3:0] g, logic [1:0] sx, logic v, logic o);
    vec_t t;
    t.sel = sel; t.rst = r; t.req = rq; t.i = d;
    t.gnt = g; t.s = sx; t.valid = v; t.out = o;
    vecs.push_back(t);
  endfunction

  task automatic check(input int idx, input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL vec%0d %s: got %b expected %b", idx, name, act, exp);
    end
  endtask

  initial begin
    vec_t e;
    logic [3:0] ga;
    logic [1:0] sa;
    logic       va, oa;
    logic [3:0] a_pat;

    rst0 = 1'b1; rst1 = 1'b1;
    req0 = 4'b0; req1 = 4'b0; i0 = 4'b0; i1 = 4'b0;

    // Reset held two cycles with all requests up.
    add(0, 1, 4'b1111, 4'b1010, 4'b0000, 2'd0, 0, 0);
    add(0, 1, 4'b1111, 4'b1010, 4'b0000, 2'd0, 0, 0);
    // Full rotation, each burst exactly 4 cycles, out = i[s].
    a_pat = 4'b1010;
    for (int g = 0; g < 4; g++)
      for (int c = 0; c < 4; c++)
        add(0, 0, 4'b1111, a_pat, 4'b0001 << g, 2'(g), 1, a_pat[g]);
    // Pointer at 3 -> requester 2 only: 2 cycles, then early release to idle.
    add(0, 0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 1);
    add(0, 0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 1);
    add(0, 0, 4'b0000, 4'b0100, 4'b0000, 2'd2, 0, 0);
    add(0, 0, 4'b0000, 4'b0100, 4'b0000, 2'd2, 0, 0);
    // Sole requester 0: re-granted across burst boundary with no gap.
    for (int c = 0; c < 6; c++)
      add(0, 0, 4'b0001, 4'b0001, 4'b0001, 2'd0, 1, 1);
    // Requester 3 joins mid-burst: burst of 0 completes, then 3, then back to 0.
    add(0, 0, 4'b1001, 4'b0001, 4'b0001, 2'd0, 1, 1);
    add(0, 0, 4'b1001, 4'b0001, 4'b0001, 2'd0, 1, 1);
    for (int c = 0; c < 4; c++)
      add(0, 0, 4'b1001, 4'b0001, 4'b1000, 2'd3, 1, 0);
    add(0, 0, 4'b1001, 4'b0001, 4'b0001, 2'd0, 1, 1);
    // Finish burst of 0, grant 1, then reset on its second cycle.
    for (int c = 0; c < 3; c++)
      add(0, 0, 4'b1111, 4'b0101, 4'b0001, 2'd0, 1, 1);
    add(0, 0, 4'b1111, 4'b0101, 4'b0010, 2'd1, 1, 0);
    add(0, 1, 4'b1111, 4'b0101, 4'b0000, 2'd0, 0, 0);
    add(0, 0, 4'b1111, 4'b0101, 4'b0001, 2'd0, 1, 1);
    add(0, 0, 4'b0001, 4'b0101, 4'b0001, 2'd0, 1, 1);
    // HOLD_CYCLES=1: grant alternates 0 and 2 every cycle.
    add(1, 1, 4'b0101, 4'b0100, 4'b0000, 2'd0, 0, 0);
    add(1, 1, 4'b0101, 4'b0100, 4'b0000, 2'd0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      add(1, 0, 4'b0101, 4'b0100, 4'b0001, 2'd0, 1, 0);
      add(1, 0, 4'b0101, 4'b0100, 4'b0100, 2'd2, 1, 1);
    end

    foreach (vecs[k]) begin
      @(negedge clk);
      if (vecs[k].sel == 1'b0) begin
        rst0 = vecs[k].rst; req0 = vecs[k].req; i0 = vecs[k].i;
        rst1 = 1'b1; req1 = 4'b0; i1 = 4'b0;
      end else begin
        rst0 = 1'b1; req0 = 4'b0; i0 = 4'b0;
        rst1 = vecs[k].rst; req1 = vecs[k].req; i1 = vecs[k].i;
      end
      sb.push_back(vecs[k]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      if (e.sel == 1'b0) begin
        ga = gnt0; sa = s0; va = valid0; oa = out0;
      end else begin
        ga = gnt1; sa = s1; va = valid1; oa = out1;
      end
      check(k, "gnt", ga, e.gnt);
      check(k, "s", {2'b00, sa}, {2'b00, e.s});
      check(k, "valid", {3'b000, va}, {3'b000, e.valid});
      check(k, "out", {3'b000, oa}, {3'b000, e.out});
      check(k, "valid_eq_or_gnt", {3'b000, va}, {3'b000, |ga});
      check(k, "gnt_onehot0", {3'b000, $onehot0(ga)}, 4'b0001);
      if (va) check(k, "gnt_eq_onehot_s", ga, 4'b0001 << sa);
    end

    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
